osd_digit_overlay: RTL and testbench

Pixel-pipeline stage that sits directly upstream of the 2048×8 font ROM `osd_rom` and downstream of the video timing source feeding the HDMI output. It addresses the ROM from the live raster position and consumes its 8-bit glyph rows to draw an N-digit decimal readout over the incoming RGB stream. Typical readouts are frame rate or a frame counter. Video timing passes through with fixed 2-cycle latency.

---
 rtl/osd_pkg.sv | 23 ++
 rtl/osd_pos_cnt.sv | 38 +++
 rtl/osd_digit_overlay.sv | 107 ++++++++++
 tb/tb_osd_digit_overlay.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// osd_pkg: shared font geometry, counter width and ROM address packing for the OSD overlay
package osd_pkg;
   localparam int GLYPH_W    = 16;
   localparam int GLYPH_H    = 32;
   localparam int ROM_AW     = 11;
   localparam int ROM_DW     = 8;
   localparam int NUM_GLYPHS = 32;
   localparam int CNT_W      = 12;
   localparam int GLYPH_AW   = $clog2(NUM_GLYPHS);
   localparam int ROW_AW     = $clog2(GLYPH_H);
   typedef logic [CNT_W-1:0] cnt_t;
   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        de;
      logic [23:0] data;
   } vid_t;
   function automatic logic [ROM_AW-1:0] pack_addr(input logic [GLYPH_AW-1:0] glyph,
                                                   input logic [ROW_AW-1:0]   row,
                                                   input logic                half);
      return {glyph, row, half};
   endfunction
endpackage

// File: rtl/osd_pos_cnt.sv
// osd_pos_cnt: raster column/line counters, sync/enable edge detection and frame-valid flag
module osd_pos_cnt
   import osd_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_vs,
   input  logic i_de,
   output cnt_t x_cnt,
   output cnt_t y_cnt,
   output logic vs_rise,
   output logic frame_ok
);
   logic vs_d;
   logic de_d;
   logic de_fall;
   assign vs_rise = i_vs & ~vs_d;
   assign de_fall = de_d & ~i_de;
   // edge history; frame_ok stays low after reset until a frame boundary is seen
   always_ff @(posedge clk)
      if (rst) begin
         vs_d     <= 1'b0;
         de_d     <= 1'b0;
         frame_ok <= 1'b0;
      end else begin
         vs_d     <= i_vs;
         de_d     <= i_de;
         if (vs_rise) frame_ok <= 1'b1;
      end
   // column of the current active beat; clear after the line ends so the next beat is column 0
   always_ff @(posedge clk)
      if (rst || de_fall) x_cnt <= '0;
      else if (i_de && x_cnt != '1) x_cnt <= x_cnt + 1'b1;
   // line index since the last frame boundary; the vs clear beats a coincident line end
   always_ff @(posedge clk)
      if (rst || vs_rise) y_cnt <= '0;
      else if (de_fall && y_cnt != '1) y_cnt <= y_cnt + 1'b1;
endmodule

// File: rtl/osd_digit_overlay.sv
// osd_digit_overlay: draws an N-digit BCD readout from a font ROM over an RGB stream, 2-cycle latency
module osd_digit_overlay
   import osd_pkg::*;
#(
   parameter logic [CNT_W-1:0] H_START  = 12'd32,
   parameter logic [CNT_W-1:0] V_START  = 12'd32,
   parameter int               N_DIGITS = 4,
   parameter logic [23:0]      FG_COLOR = 24'hFFFFFF,
   parameter bit               BG_EN    = 1'b0,
   parameter logic [23:0]      BG_COLOR = 24'h000000
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_vs,
   input  logic                  i_hs,
   input  logic                  i_de,
   input  logic [23:0]           i_data,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic                  osd_en,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [ROM_DW-1:0]     rom_data,
   output logic                  o_vs,
   output logic                  o_hs,
   output logic                  o_de,
   output logic [23:0]           o_data
);
   localparam int WIN_W = GLYPH_W * N_DIGITS;
   cnt_t                  x_cnt;
   cnt_t                  y_cnt;
   cnt_t                  rel_x;
   cnt_t                  rel_y;
   logic                  vs_rise;
   logic                  frame_ok;
   logic [4*N_DIGITS-1:0] dig_lat;
   logic                  en_lat;
   logic [3:0]            dig_arr [8];
   logic [3:0]            cur_dig;
   logic                  in_win;
   logic                  valid;
   vid_t                  s1;
   logic                  win1;
   logic                  valid1;
   logic [2:0]            bit1;
   logic                  glyph_px;
   osd_pos_cnt u_pos (
      .clk      (clk),
      .rst      (rst),
      .i_vs     (i_vs),
      .i_de     (i_de),
      .x_cnt    (x_cnt),
      .y_cnt    (y_cnt),
      .vs_rise  (vs_rise),
      .frame_ok (frame_ok)
   );
   // slot 0 is the leftmost digit, taken from the top nibble; unused slots read as 0
   for (genvar g = 0; g < 8; g++) begin : g_dig
      if (g < N_DIGITS) begin : g_on
         assign dig_arr[g] = dig_lat[4*(N_DIGITS-1-g) +: 4];
      end else begin : g_off
         assign dig_arr[g] = 4'd0;
      end
   end
   assign rel_x    = x_cnt - H_START;
   assign rel_y    = y_cnt - V_START;
   assign in_win   = i_de & frame_ok & (x_cnt >= H_START) & (rel_x < CNT_W'(WIN_W))
                   & (y_cnt >= V_START) & (rel_y < CNT_W'(GLYPH_H));
   assign cur_dig  = dig_arr[rel_x[6:4]];
   assign valid    = cur_dig <= 4'd9;
   assign rom_addr = in_win ? pack_addr(GLYPH_AW'(cur_dig), rel_y[ROW_AW-1:0], rel_x[3]) : '0;
   // readout value and enable only change at frame boundaries, so a frame never tears
   always_ff @(posedge clk)
      if (rst) begin
         dig_lat <= '0;
         en_lat  <= 1'b0;
      end else if (vs_rise) begin
         dig_lat <= digits;
         en_lat  <= osd_en;
      end
   // stage 1: hold the pixel while the ROM row for its address is fetched
   always_ff @(posedge clk)
      if (rst) begin
         s1     <= '0;
         win1   <= 1'b0;
         valid1 <= 1'b0;
         bit1   <= 3'd0;
      end else begin
         s1     <= {i_vs, i_hs, i_de, i_data};
         win1   <= in_win;
         valid1 <= valid;
         bit1   <= 3'd7 - rel_x[2:0];
      end
   assign glyph_px = en_lat & win1 & valid1 & rom_data[bit1];
   // stage 2: pick glyph, window background or the original pixel
   always_ff @(posedge clk)
      if (rst) begin
         o_vs   <= 1'b0;
         o_hs   <= 1'b0;
         o_de   <= 1'b0;
         o_data <= '0;
      end else begin
         o_vs   <= s1.vs;
         o_hs   <= s1.hs;
         o_de   <= s1.de;
         o_data <= glyph_px ? FG_COLOR : (en_lat && win1 && BG_EN) ? BG_COLOR : s1.data;
      end
endmodule

// File: tb/tb_osd_digit_overlay.sv
// tb_osd_digit_overlay: raster-driven bench with a frame-level model, per-cycle compare and pinned literals
module tb_osd_digit_overlay;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_vs, i_hs, i_de;
   logic [23:0] i_data;
   logic [7:0]  digits;
   logic        osd_en;
   logic [10:0] da_addr, db_addr;
   logic [7:0]  da_rd, db_rd;
   logic        da_vs, da_hs, da_de, db_vs, db_hs, db_de;
   logic [23:0] da_data, db_data;
   localparam logic [23:0] BG = 24'h0000AA;
   localparam logic [23:0] FG = 24'hFFFFFF;
   int  cur_x, cur_y, frame_no;
   bit  armed, const_data;
   logic [7:0] ev_digits;
   bit  ev_en, ev_rst;
   int  n_chk, n_pass;
   logic        fok_m, en_m, vsp_m;
   logic [7:0]  dig_m;
   logic [26:0] pa1, pa2, pb1, pb2;
   int  hx1, hx2, hy1, hy2, hf1, hf2;
   bit  hde1, hde2;
   logic [23:0] hd1, hd2;

   always #5 clk = ~clk;

   osd_digit_overlay #(.H_START(12'd8), .V_START(12'd4), .N_DIGITS(2)) da (
      .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_data(i_data),
      .digits(digits), .osd_en(osd_en), .rom_addr(da_addr), .rom_data(da_rd),
      .o_vs(da_vs), .o_hs(da_hs), .o_de(da_de), .o_data(da_data));
   osd_digit_overlay #(.H_START(12'd8), .V_START(12'd4), .N_DIGITS(2), .BG_EN(1'b1), .BG_COLOR(BG)) db (
      .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_data(i_data),
      .digits(digits), .osd_en(osd_en), .rom_addr(db_addr), .rom_data(db_rd),
      .o_vs(db_vs), .o_hs(db_hs), .o_de(db_de), .o_data(db_data));

   // test font: each byte is {glyph[2:0], row}
   function automatic logic [7:0] font(input logic [10:0] a);
      return {a[8:6], a[5:1]};
   endfunction

   // synchronous-read font ROMs, one per instance
   always @(posedge clk) begin
      da_rd <= font(da_addr);
      db_rd <= font(db_addr);
   end

   function automatic bit in_w();
      return i_de && fok_m && cur_x >= 8 && cur_x < 40 && cur_y >= 4 && cur_y < 36;
   endfunction

   function automatic int dig_at();
      int slot = (cur_x - 8) / 16;
      return int'((dig_m >> (4 * (1 - slot))) & 8'hF);
   endfunction

   function automatic logic [10:0] exp_addr();
      if (!in_w()) return 11'd0;
      return 11'(dig_at() * 64 + (cur_y - 4) * 2 + ((cur_x - 8) % 16) / 8);
   endfunction

   function automatic logic [26:0] exp_out(input bit bg);
      bit px = 0;
      logic [7:0] b;
      logic [23:0] dat;
      if (in_w() && en_m && dig_at() <= 9) begin
         b  = 8'((dig_at() % 8) * 32 + (cur_y - 4));
         px = b[7 - ((cur_x - 8) % 16) % 8];
      end
      dat = px ? FG : (in_w() && en_m && bg) ? BG : i_data;
      return {i_vs, i_hs, i_de, dat};
   endfunction

   // frame-level model: latches at each vs rise, outputs appear two clocks after their inputs
   always @(posedge clk) begin
      hx1 <= cur_x; hx2 <= hx1; hy1 <= cur_y; hy2 <= hy1;
      hf1 <= frame_no; hf2 <= hf1; hde1 <= i_de; hde2 <= hde1;
      hd1 <= i_data; hd2 <= hd1;
      if (rst) begin
         fok_m <= 0; en_m <= 0; dig_m <= 0; vsp_m <= 0;
         pa1 <= 0; pa2 <= 0; pb1 <= 0; pb2 <= 0;
      end else begin
         vsp_m <= i_vs;
         if (i_vs && !vsp_m) begin
            fok_m <= 1; dig_m <= digits; en_m <= osd_en;
         end
         pa1 <= exp_out(0); pa2 <= pa1;
         pb1 <= exp_out(1); pb2 <= pb1;
      end
   end

   task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (frame %0d x %0d y %0d)", nm, act, exp, frame_no, cur_x, cur_y);
   endtask

   function automatic bit now_at(int f, int x, int y);
      return i_de && frame_no == f && cur_x == x && cur_y == y;
   endfunction

   function automatic bit out_at(int f, int x, int y);
      return hde2 && hf2 == f && hx2 == x && hy2 == y;
   endfunction

   // compare every cycle against the model, plus hand-computed pins
   always @(negedge clk) if (armed) begin
      chk("da_out", {da_vs, da_hs, da_de, da_data}, pa2);
      chk("db_out", {db_vs, db_hs, db_de, db_data}, pb2);
      chk("da_addr", 27'(da_addr), 27'(exp_addr()));
      chk("db_addr", 27'(db_addr), 27'(exp_addr()));
      if (rst && frame_no == 0) chk("rst_zero", {db_vs, db_hs, db_de, db_data} | 27'(db_addr), 27'd0);
      if (out_at(1, 20, 10)) chk("nosync_pass", 27'(da_data), 27'h123456);
      if (now_at(2, 8, 4))   chk("addr_3_r0_h0", 27'(da_addr), 27'h0C0);
      if (now_at(2, 16, 4))  chk("addr_3_r0_h1", 27'(da_addr), 27'h0C1);
      if (now_at(2, 24, 35)) chk("addr_7_r31", 27'(da_addr), 27'h1FE);
      if (out_at(2, 8, 4))   chk("dec_bit7_off", 27'(da_data), 27'(hd2));
      if (out_at(2, 9, 4))   chk("dec_bit6_on", 27'(da_data), 27'(FG));
      if (out_at(3, 8, 4))   chk("inval_bg", 27'(db_data), 27'(BG));
      if (out_at(3, 24, 4))  chk("slot1_5_on", 27'(db_data), 27'(FG));
      if (out_at(3, 25, 4))  chk("slot1_5_bg", 27'(db_data), 27'(BG));
      if (out_at(4, 24, 20)) chk("midfrm_keep", 27'(db_data), 27'(FG));
      if (out_at(5, 8, 4))   chk("new9_off", 27'(db_data), 27'(BG));
      if (out_at(5, 10, 4))  chk("new9_on", 27'(da_data), 27'(FG));
      if (out_at(6, 10, 4))  chk("en_off_pass", 27'(da_data), 27'(hd2));
      if (out_at(7, 9, 20))  chk("rst_mid_pass", 27'(da_data), 27'(hd2));
      if (out_at(8, 9, 19))  chk("short_row15", 27'(da_data), 27'(FG));
      if (out_at(9, 9, 4))   chk("overlay_back", 27'(da_data), 27'(FG));
   end

   task automatic step(input bit vs, input bit hs, input bit de, input int x, input int y);
      @(posedge clk);
      #1;
      i_vs = vs; i_hs = hs; i_de = de; cur_x = x; cur_y = y;
      i_data = const_data ? 24'h123456 : de ? {12'(x), 12'(y)} : 24'hABCDEF;
   endtask

   task automatic frame(input int fno, input bit do_vs, input int nlines, input int ev_line);
      frame_no = fno;
      if (do_vs) repeat (2) step(1, 0, 0, -1, -1);
      repeat (4) step(0, 0, 0, -1, -1);
      for (int l = 0; l < nlines; l++) begin
         for (int x = 0; x < 64; x++) step(0, 0, 1, x, l);
         for (int b = 0; b < 8; b++) begin
            step(0, b >= 2 && b < 5, 0, -1, -1);
            if (l == ev_line && b == 0) begin
               digits = ev_digits; osd_en = ev_en; rst = ev_rst;
            end
            if (l == ev_line && b == 1) rst = 0;
         end
      end
   endtask

   initial begin
      rst = 1; i_vs = 0; i_hs = 0; i_de = 0; i_data = 0; cur_x = -1; cur_y = -1;
      digits = 8'h37; osd_en = 1; const_data = 1; frame_no = 0;
      ev_digits = 0; ev_en = 0; ev_rst = 0; n_chk = 0; n_pass = 0; armed = 0;
      step(0, 0, 0, -1, -1);
      armed = 1;
      repeat (4) step(0, 0, 0, -1, -1);
      rst = 0;
      frame(1, 0, 40, -1);
      const_data = 0;
      frame(2, 1, 40, -1);
      digits = 8'hA5;
      ev_digits = 8'h91; ev_en = 1;
      frame(3, 1, 40, -1);
      frame(4, 1, 40, 10);
      ev_en = 0;
      frame(5, 1, 40, 10);
      frame(6, 1, 40, -1);
      digits = 8'h37; osd_en = 1; ev_digits = 8'h37; ev_en = 1; ev_rst = 1;
      frame(7, 1, 40, 10);
      ev_rst = 0;
      frame(8, 1, 20, -1);
      frame(9, 1, 40, -1);
      repeat (4) step(0, 0, 0, -1, -1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
